// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulation datapath: lane count, default widths
// and the accumulator controller state encoding.
package mac_pkg;

    localparam int unsigned LANES       = 4;
    localparam int unsigned DEF_BW      = 4;
    localparam int unsigned DEF_PSUM_BW = 16;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/mac_dot4.sv
// Combinational 4-lane dot product: unsigned x lanes times signed w lanes,
// each product sign-extended and summed modulo 2^psum_bw.
module mac_dot4
    import mac_pkg::*;
#(
    parameter int bw      = DEF_BW,
    parameter int psum_bw = DEF_PSUM_BW
) (
    input  logic [LANES*bw-1:0]      x_vec,
    input  logic [LANES*bw-1:0]      w_vec,
    output logic signed [psum_bw-1:0] dot
);

    logic signed [2*bw:0] xe;
    logic signed [2*bw:0] we;
    logic signed [2*bw:0] prod;

    always_comb begin
        dot  = '0;
        xe   = '0;
        we   = '0;
        prod = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            // x is zero-extended through a sign bit of 0; w keeps its own sign
            xe   = (2*bw+1)'($signed({1'b0, x_vec[i*bw +: bw]}));
            we   = (2*bw+1)'($signed(w_vec[i*bw +: bw]));
            prod = xe * we;
            dot  = dot + psum_bw'(prod);
        end
    end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Receive side of the 4-lane MAC stream: accumulates per-tuple dot products into a
// psum and hands one result per frame to the writeback port over valid/ready.
module mac_accum_ctrl
    import mac_pkg::*;
#(
    parameter int bw      = DEF_BW,
    parameter int psum_bw = DEF_PSUM_BW,
    parameter int max_len = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*bw-1:0]            x_vec,
    input  logic [LANES*bw-1:0]            w_vec,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [psum_bw-1:0]             out_psum,
    output logic [$clog2(max_len+1)-1:0]   out_len
);

    localparam int len_bw = $clog2(max_len+1);

    state_t                    state;
    state_t                    state_nxt;
    logic [psum_bw-1:0]        acc;
    logic [len_bw-1:0]         cnt;
    logic [len_bw-1:0]         cnt_nxt;
    logic signed [psum_bw-1:0] dot;
    logic [psum_bw-1:0]        sum;
    logic                      accept;
    logic                      close;

    mac_dot4 #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_dot4 (
        .x_vec (x_vec),
        .w_vec (w_vec),
        .dot   (dot)
    );

    assign accept  = in_valid & in_ready;
    assign cnt_nxt = cnt + len_bw'(1);
    assign sum     = acc + $unsigned(dot);
    assign close   = accept & (in_last | (cnt_nxt == len_bw'(max_len)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (close)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = ACC;
            default:                state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready = (state == ACC);
    end

    // accept only happens in ACC, so the drain branch can never collide with a close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_psum  <= '0;
            out_len   <= '0;
        end else if (accept) begin
            if (close) begin
                out_psum  <= sum;
                out_len   <= cnt_nxt;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt_nxt;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Randomized bench for mac_accum_ctrl: a 16-bit and an 8-bit instance run in lockstep
// on shared inputs and are checked against a frame-level arithmetic model.
module tb_mac_accum_ctrl;

    localparam int MAX_LEN = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] x_vec;
    logic [15:0] w_vec;

    logic        in_ready,  out_valid;
    logic [15:0] out_psum;
    logic [4:0]  out_len;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_psum8;
    logic [4:0]  out_len8;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_q[$];
    int exp_sum;
    int exp_len;

    always #5 clk = ~clk;

    mac_accum_ctrl #(.bw(4), .psum_bw(16), .max_len(MAX_LEN)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_vec(x_vec), .w_vec(w_vec), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_psum(out_psum), .out_len(out_len)
    );

    mac_accum_ctrl #(.bw(4), .psum_bw(8), .max_len(MAX_LEN)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .x_vec(x_vec), .w_vec(w_vec), .in_last(in_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_psum(out_psum8), .out_len(out_len8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dot_ref(input logic [15:0] x, input logic [15:0] w);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] xn;
            logic [3:0] wn;
            xn = x[i*4 +: 4];
            wn = w[i*4 +: 4];
            s += int'(xn) * int'($signed(wn));
        end
        return s;
    endfunction

    function automatic int frame_sum();
        int s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result();
        check("valid16", out_valid, 1);
        check("psum16",  out_psum,  exp_sum & 32'hFFFF);
        check("len16",   out_len,   exp_len);
        check("valid8",  out_valid8, 1);
        check("psum8",   out_psum8, exp_sum & 32'hFF);
        check("len8",    out_len8,  exp_len);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] w, input logic last,
                        output bit closed);
        int budget = 0;
        closed   = 0;
        x_vec    = x;
        w_vec    = w;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && budget < 20) begin
            step();
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        x_vec    = 16'($urandom);
        w_vec    = 16'($urandom);
        frame_q.push_back(dot_ref(x, w));
        if (last || frame_q.size() == MAX_LEN) begin
            exp_sum = frame_sum();
            exp_len = frame_q.size();
            frame_q.delete();
            closed = 1;
            check_result();
        end else begin
            check("no_early_valid16", out_valid, 0);
            check("no_early_valid8",  out_valid8, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom);
            x_vec     = 16'($urandom);
            w_vec     = 16'($urandom);
            step();
        end
        out_ready = 1'b0;
    endtask

    // hold the result with random input traffic, then release it
    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            x_vec     = 16'($urandom);
            w_vec     = 16'($urandom);
            step();
            check("hold_in_ready", in_ready, 0);
            check_result();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_valid16", out_valid, 0);
        check("drain_valid8",  out_valid8, 0);
        check("drain_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit closed;
        int len;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        x_vec     = '0;
        w_vec     = '0;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_psum",  out_psum,  0);
        check("rst_len",   out_len,   0);
        check("rst_ready", in_ready,  1);
        reset = 1'b0;
        step();

        // single-tuple frame
        send(16'h4321, 16'h1111, 1'b1, closed);
        check("t1_psum", out_psum, 16'd10);
        drain(1);

        // negative products, result held 5 cycles under input noise
        send(16'hFFFF, 16'h8888, 1'b0, closed);
        send(16'hFFFF, 16'h8888, 1'b0, closed);
        send(16'hFFFF, 16'h8888, 1'b1, closed);
        check("t2_psum", out_psum, 16'hFA60);
        check("t2_len",  out_len,  3);
        drain(5);

        // auto-close on the max_len-th tuple
        for (int i = 0; i < MAX_LEN; i++) send(16'h0001, 16'h0007, 1'b0, closed);
        check("t4_closed", 32'(closed), 1);
        check("t4_psum", out_psum, 16'd112);
        check("t4_len",  out_len,  16);
        drain(2);

        // reset mid-frame discards the partial sum
        send(16'h0005, 16'h0003, 1'b0, closed);
        send(16'h0005, 16'h0003, 1'b0, closed);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        frame_q.delete();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_len",   out_len,   0);
        step();
        check("t5_no_valid", out_valid, 0);
        send(16'h0002, 16'h000D, 1'b1, closed);
        check("t5_psum", out_psum, 16'hFFFA);
        drain(1);

        // wrap in the 8-bit instance, idle gaps mid-frame
        send(16'hFFFF, 16'h7777, 1'b0, closed);
        idle(3);
        send(16'hFFFF, 16'h7777, 1'b0, closed);
        idle(2);
        send(16'hFFFF, 16'h7777, 1'b1, closed);
        check("t6_psum8", out_psum8, 8'hEC);
        check("t6_psum16", out_psum, 16'h04EC);

        // reset while a result is pending
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        check("done_rst_valid", out_valid, 0);
        check("done_rst_ready", in_ready, 1);
        step();

        // random frames, lengths past max_len exercise auto-close
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                send(16'($urandom), 16'($urandom), 1'(k == len - 1), closed);
                if (closed) break;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            drain($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
